mainfsm: RTL and testbench
==========================

Name: mainfsm

Overview:
- Multicycle ARM main control FSM. Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Sits in the controller directly upstream of condlogic.
  - RegW feeds condlogic RegW.
  - MemW feeds condlogic MemW.
  - Branch is ORed with the PC-write decode to form condlogic PCS.
- Drives the datapath mux selects and IR/PC enables.
- Adds a memory-ready handshake so slow memory can stall fetch and load/store.

Parameters:
- MEM_HANDSHAKE, 1, when 0 the MemReady input is ignored and treated as constant 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset; forces state to FETCH
- Op  input  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
- Funct  input  6  instruction bits [25:20]; Funct[5]=I (immediate), Funct[0]=L (load)
- MemReady  input  1  memory completes the current access this cycle
- IRWrite  output  1  load instruction register
- NextPC  output  1  PC update enable (PC+4 path)
- AdrSrc  output  1  0 = PC, 1 = ALU result as memory address
- ALUSrcA  output  1  0 = register A, 1 = PC
- ALUSrcB  output  2  00 = reg B, 01 = ExtImm, 10 = constant 4
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUOp  output  1  1 = ALU decoder uses Funct; 0 = add
- RegW  output  1  register write request (to condlogic)
- MemW  output  1  memory write request (to condlogic)
- Branch  output  1  branch request (to PCS logic)
- Undef  output  1  undefined-instruction trap flag (see Optional Feature)

Behaviour:
- Moore machine. All outputs decode combinationally from the state register only, except the MemReady qualification noted below.
- Reset: state=FETCH asynchronously.
  - While reset is high, outputs take FETCH values, except IRWrite=0 and NextPC=0 (gated by ~reset).
  - Undef=0.
- Unlisted outputs are 0 in every state.
- Per-state outputs and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0. IRWrite=NextPC=MemReady. MemReady=1 -> DECODE, else stay.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state:
    - Op=01 -> MEMADR
    - Op=00 and Funct[5]=0 -> EXECR
    - Op=00 and Funct[5]=1 -> EXECI
    - Op=10 -> BRANCH
    - Op=11 -> FETCH
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Funct[0]=1 -> MEMRD, else -> MEMWR.
  - MEMRD: AdrSrc=1. MemReady=1 -> MEMWB, else stay.
  - MEMWB: ResultSrc=01, RegW=1 -> FETCH.
  - MEMWR: AdrSrc=1, MemW=1, held for every cycle in the state. MemReady=1 -> FETCH, else stay.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1 -> ALUWB.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1 -> ALUWB.
  - ALUWB: ResultSrc=00, RegW=1 -> FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1 -> FETCH.
- Latency with MemReady tied 1:
  - Data-processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Each wait cycle adds 1.
- IRWrite and NextPC pulse exactly once per instruction, regardless of stall length.
- Op and Funct are sampled only in DECODE and MEMADR; IR is stable there.
- Reset mid-instruction (e.g. in MEMWR): state returns to FETCH immediately, MemW drops asynchronously, and no partial RegW or MemW is issued afterwards.
- Unencoded state values -> FETCH via default.

Optional Feature:
- Macro MAINFSM_UNDEF_TRAP_EN.
- Defined:
  - DECODE with Op=11 -> UNDEF state.
  - In UNDEF, Undef=1 and all enables and writes are 0.
  - UNDEF is sticky until reset.
- Not defined:
  - No UNDEF state exists.
  - Op=11 retires as a NOP (DECODE -> FETCH).
  - Undef is tied 0.

Decomposition:
- Package mainfsm_pkg:
  - statetype enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, UNDEF.
  - Op code constants: OP_DP, OP_MEM, OP_BR.
  - ALUSrcB constants: SRCB_REG, SRCB_IMM, SRCB_4.
  - ResultSrc constants: RES_ALUOUT, RES_DATA, RES_ALU.
- One sub-module, mainfsm_outdec: pure combinational state -> control-vector decode. The top keeps the state register, next-state logic and MemReady qualification.

Test Plan:
- Reset held 3 cycles, release, Op=00 and Funct=000000, MemReady=1 -> states FETCH, DECODE, EXECR, ALUWB, FETCH. ALUOp=1 in EXECR; RegW=1 for exactly 1 cycle in ALUWB; IRWrite=1 only in cycle 1.
- Op=01, Funct=011001 (LDR), MemReady=0 for 2 cycles in MEMRD -> MEMRD lasts 3 cycles with AdrSrc=1. MEMWB follows with ResultSrc=01 and RegW=1. Total 7 cycles.
- Op=01, Funct=011000 (STR), MemReady low 1 cycle in FETCH and 1 cycle in MEMWR -> IRWrite and NextPC pulse once. MemW=1 for 2 cycles. No RegW.
- Op=10 -> BRANCH with Branch=1, ALUSrcB=01, ResultSrc=10; returns to FETCH after 3 cycles total.
- Reset asserted asynchronously mid-MEMWR -> MemW falls before the next clk edge. After release the state is FETCH and IRWrite=1.
- Op=11:
  - With MAINFSM_UNDEF_TRAP_EN: Undef=1 from the cycle after DECODE, held for 10+ cycles with all write enables 0.
  - Without the macro: back to FETCH and Undef=0.

Source files
------------

// File: rtl/mainfsm_pkg.sv
// rtl/mainfsm_pkg.sv - shared types and encodings for the multicycle ARM main control FSM
// Purpose: state enum, opcode / mux-select constants and the control-vector struct.
// Optional feature macro: MAINFSM_UNDEF_TRAP_EN (adds the sticky UNDEF state).
package mainfsm_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH
`ifdef MAINFSM_UNDEF_TRAP_EN
    ,
    UNDEF
`endif
  } statetype;

  // Op field, instruction bits [27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  // ResultSrc selects
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Raw per-state control vector; irwrite/nextpc are qualified later by MemReady and reset
  typedef struct packed {
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       undef;
  } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// rtl/mainfsm_outdec.sv - combinational state to control-vector decode for mainfsm
// Purpose: Moore output table; every field not listed for a state stays 0.
// Ports:
//   state  in   current FSM state
//   ctrl   out  raw control vector (irwrite/nextpc not yet MemReady-qualified)
// Optional feature macro: MAINFSM_UNDEF_TRAP_EN (decodes the UNDEF state).
module mainfsm_outdec
  import mainfsm_pkg::*;
(
  input  statetype state,
  output ctrl_t    ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.irwrite   = 1'b1;
        ctrl.nextpc    = 1'b1;
        ctrl.adrsrc    = 1'b0;
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_4;
        ctrl.resultsrc = RES_ALU;
        ctrl.aluop     = 1'b0;
      end
      DECODE: begin
        // precompute PC+8 in case the instruction reads R15
        ctrl.alusrca   = 1'b1;
        ctrl.alusrcb   = SRCB_4;
        ctrl.resultsrc = RES_ALU;
      end
      MEMADR: begin
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = 1'b0;
      end
      MEMRD: begin
        ctrl.adrsrc = 1'b1;
      end
      MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regw      = 1'b1;
      end
      MEMWR: begin
        ctrl.adrsrc = 1'b1;
        ctrl.memw   = 1'b1;
      end
      EXECR: begin
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = SRCB_REG;
        ctrl.aluop   = 1'b1;
      end
      EXECI: begin
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = 1'b1;
      end
      ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regw      = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca   = 1'b0;
        ctrl.alusrcb   = SRCB_IMM;
        ctrl.resultsrc = RES_ALU;
        ctrl.aluop     = 1'b0;
        ctrl.branch    = 1'b1;
      end
`ifdef MAINFSM_UNDEF_TRAP_EN
      UNDEF: begin
        ctrl.undef = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - multicycle ARM main control FSM with memory-ready handshake
// Purpose: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
// Ports:
//   clk, reset           clock; asynchronous active-high reset to FETCH
//   Op[1:0], Funct[5:0]  instruction fields, sampled in DECODE and MEMADR only
//   MemReady             memory finishes the current access this cycle
//   IRWrite, NextPC      IR load / PC+4 enables, one pulse per instruction
//   AdrSrc, ALUSrcA, ALUSrcB[1:0], ResultSrc[1:0], ALUOp  datapath selects
//   RegW, MemW, Branch   write/branch requests to condlogic
//   Undef                undefined-instruction trap flag
// Parameter MEM_HANDSHAKE: 0 ignores MemReady (treated as 1).
// Optional feature macro: MAINFSM_UNDEF_TRAP_EN (Op=11 traps to sticky UNDEF).
module mainfsm
  import mainfsm_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Undef
);

  statetype state, nextstate;
  ctrl_t    ctrl;
  logic     memrdy;

  // Funct[4:1] are consumed by the ALU decoder, not by this FSM
  logic     unused_funct;
  assign unused_funct = &Funct[4:1];

  assign memrdy = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextstate;
  end

  // Next-state logic
  always_comb begin
    nextstate = FETCH;
    case (state)
      FETCH:  nextstate = memrdy ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_MEM:  nextstate = MEMADR;
          OP_DP:   nextstate = Funct[5] ? EXECI : EXECR;
          OP_BR:   nextstate = BRANCH;
`ifdef MAINFSM_UNDEF_TRAP_EN
          default: nextstate = UNDEF;
`else
          default: nextstate = FETCH;  // Op=11 retires as a NOP
`endif
        endcase
      end
      MEMADR: nextstate = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  nextstate = memrdy ? MEMWB : MEMRD;
      MEMWB:  nextstate = FETCH;
      MEMWR:  nextstate = memrdy ? FETCH : MEMWR;
      EXECR:  nextstate = ALUWB;
      EXECI:  nextstate = ALUWB;
      ALUWB:  nextstate = FETCH;
      BRANCH: nextstate = FETCH;
`ifdef MAINFSM_UNDEF_TRAP_EN
      UNDEF:  nextstate = UNDEF;
`endif
      default: nextstate = FETCH;
    endcase
  end

  mainfsm_outdec u_outdec (
    .state (state),
    .ctrl  (ctrl)
  );

  // Outputs: IR/PC enables fire only on the cycle fetch actually completes,
  // and never while reset holds the machine in FETCH.
  always_comb begin
    IRWrite   = ctrl.irwrite & memrdy & ~reset;
    NextPC    = ctrl.nextpc & memrdy & ~reset;
    AdrSrc    = ctrl.adrsrc;
    ALUSrcA   = ctrl.alusrca;
    ALUSrcB   = ctrl.alusrcb;
    ResultSrc = ctrl.resultsrc;
    ALUOp     = ctrl.aluop;
    RegW      = ctrl.regw;
    MemW      = ctrl.memw;
    Branch    = ctrl.branch;
    Undef     = ctrl.undef;
  end

endmodule

// File: tb/tb_mainfsm.sv
// tb/tb_mainfsm.sv - directed self-checking bench for mainfsm
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch, Undef;
  logic [1:0] ALUSrcB, ResultSrc;

  int nvec = 0;
  int nerr = 0;

  mainfsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .MemReady  (MemReady),
    .IRWrite   (IRWrite),
    .NextPC    (NextPC),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .Undef     (Undef)
  );

  always #5 clk = ~clk;

  // {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,Undef}
  logic [12:0] obs;
  assign obs = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch, Undef};

  localparam logic [12:0] V_FET = 13'b1_1_0_1_10_10_0_0_0_0_0;
  localparam logic [12:0] V_FST = 13'b0_0_0_1_10_10_0_0_0_0_0;
  localparam logic [12:0] V_RST = 13'b0_0_0_1_10_10_0_0_0_0_0;
  localparam logic [12:0] V_DEC = 13'b0_0_0_1_10_10_0_0_0_0_0;
  localparam logic [12:0] V_MAD = 13'b0_0_0_0_01_00_0_0_0_0_0;
  localparam logic [12:0] V_MRD = 13'b0_0_1_0_00_00_0_0_0_0_0;
  localparam logic [12:0] V_MWB = 13'b0_0_0_0_00_01_0_1_0_0_0;
  localparam logic [12:0] V_MWR = 13'b0_0_1_0_00_00_0_0_1_0_0;
  localparam logic [12:0] V_EXR = 13'b0_0_0_0_00_00_1_0_0_0_0;
  localparam logic [12:0] V_EXI = 13'b0_0_0_0_01_00_1_0_0_0_0;
  localparam logic [12:0] V_AWB = 13'b0_0_0_0_00_00_0_1_0_0_0;
  localparam logic [12:0] V_BR  = 13'b0_0_0_0_01_10_0_0_0_1_0;
  localparam logic [12:0] V_UND = 13'b0_0_0_0_00_00_0_0_0_0_1;

  task automatic test_reset();
    reset = 1'b1; Op = 2'b00; Funct = 6'b0; MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if (obs !== V_RST) begin
        nerr++;
        $display("FAIL reset cycle %0d: got %b want %b", i, obs, V_RST);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_dp_reg();
    logic [13:0] tv [4] = '{{1'b1, V_FET}, {1'b1, V_DEC}, {1'b1, V_EXR}, {1'b1, V_AWB}};
    int nir = 0, nrw = 0;
    Op = 2'b00; Funct = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      MemReady = tv[i][13];
      @(negedge clk);
      nvec++;
      if (obs !== tv[i][12:0]) begin
        nerr++;
        $display("FAIL dp_reg cycle %0d: got %b want %b", i, obs, tv[i][12:0]);
      end
      nir += int'(IRWrite); nrw += int'(RegW);
      @(posedge clk); #1;
    end
    nvec++;
    if (nir != 1 || nrw != 1) begin
      nerr++;
      $display("FAIL dp_reg pulses: irwrite=%0d regw=%0d want 1 1", nir, nrw);
    end
  endtask

  task automatic test_ldr_stall();
    logic [13:0] tv [7] = '{{1'b1, V_FET}, {1'b1, V_DEC}, {1'b1, V_MAD},
                            {1'b0, V_MRD}, {1'b0, V_MRD}, {1'b1, V_MRD}, {1'b1, V_MWB}};
    Op = 2'b01; Funct = 6'b011001;
    for (int i = 0; i < 7; i++) begin
      MemReady = tv[i][13];
      @(negedge clk);
      nvec++;
      if (obs !== tv[i][12:0]) begin
        nerr++;
        $display("FAIL ldr cycle %0d: got %b want %b", i, obs, tv[i][12:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_str_stall();
    logic [13:0] tv [6] = '{{1'b0, V_FST}, {1'b1, V_FET}, {1'b1, V_DEC},
                            {1'b1, V_MAD}, {1'b0, V_MWR}, {1'b1, V_MWR}};
    int nir = 0, npc = 0, nmw = 0, nrw = 0;
    Op = 2'b01; Funct = 6'b011000;
    for (int i = 0; i < 6; i++) begin
      MemReady = tv[i][13];
      @(negedge clk);
      nvec++;
      if (obs !== tv[i][12:0]) begin
        nerr++;
        $display("FAIL str cycle %0d: got %b want %b", i, obs, tv[i][12:0]);
      end
      nir += int'(IRWrite); npc += int'(NextPC); nmw += int'(MemW); nrw += int'(RegW);
      @(posedge clk); #1;
    end
    nvec++;
    if (nir != 1 || npc != 1 || nmw != 2 || nrw != 0) begin
      nerr++;
      $display("FAIL str pulses: irwrite=%0d nextpc=%0d memw=%0d regw=%0d want 1 1 2 0",
               nir, npc, nmw, nrw);
    end
  endtask

  task automatic test_branch();
    logic [13:0] tv [3] = '{{1'b1, V_FET}, {1'b1, V_DEC}, {1'b1, V_BR}};
    Op = 2'b10; Funct = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      MemReady = tv[i][13];
      @(negedge clk);
      nvec++;
      if (obs !== tv[i][12:0]) begin
        nerr++;
        $display("FAIL branch cycle %0d: got %b want %b", i, obs, tv[i][12:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] tv [8] = '{{1'b1, V_FET}, {1'b1, V_DEC}, {1'b1, V_EXI}, {1'b1, V_AWB},
                            {1'b1, V_FET}, {1'b1, V_DEC}, {1'b1, V_EXR}, {1'b1, V_AWB}};
    for (int i = 0; i < 8; i++) begin
      Op = 2'b00;
      Funct = (i < 4) ? 6'b100000 : 6'b000001;
      MemReady = tv[i][13];
      @(negedge clk);
      nvec++;
      if (obs !== tv[i][12:0]) begin
        nerr++;
        $display("FAIL b2b cycle %0d: got %b want %b", i, obs, tv[i][12:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_memwr();
    logic [13:0] tv [4] = '{{1'b1, V_FET}, {1'b1, V_DEC}, {1'b1, V_MAD}, {1'b0, V_MWR}};
    Op = 2'b01; Funct = 6'b011000;
    for (int i = 0; i < 4; i++) begin
      MemReady = tv[i][13];
      @(negedge clk);
      nvec++;
      if (obs !== tv[i][12:0]) begin
        nerr++;
        $display("FAIL rstmid cycle %0d: got %b want %b", i, obs, tv[i][12:0]);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    // still before the next rising edge
    #2 reset = 1'b1;
    #1;
    nvec++;
    if (MemW !== 1'b0 || obs !== V_RST) begin
      nerr++;
      $display("FAIL rstmid async: got %b memw=%b want %b", obs, MemW, V_RST);
    end
    @(posedge clk); #1;
    reset = 1'b0; MemReady = 1'b1; Op = 2'b10; Funct = 6'b000000;
    @(negedge clk);
    nvec++;
    if (obs !== V_FET) begin
      nerr++;
      $display("FAIL rstmid refetch: got %b want %b", obs, V_FET);
    end
    @(posedge clk); #1;
    @(negedge clk);
    nvec++;
    if (obs !== V_DEC) begin
      nerr++;
      $display("FAIL rstmid decode: got %b want %b", obs, V_DEC);
    end
    @(posedge clk); #1;
    @(negedge clk);
    nvec++;
    if (obs !== V_BR || MemW !== 1'b0) begin
      nerr++;
      $display("FAIL rstmid after: got %b want %b", obs, V_BR);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_undef();
`ifdef MAINFSM_UNDEF_TRAP_EN
    localparam int N = 14;
    logic [13:0] tv [N];
    tv[0] = {1'b1, V_FET};
    tv[1] = {1'b1, V_DEC};
    for (int k = 2; k < N; k++) tv[k] = {1'b1, V_UND};
`else
    localparam int N = 3;
    logic [13:0] tv [N];
    tv[0] = {1'b1, V_FET};
    tv[1] = {1'b1, V_DEC};
    tv[2] = {1'b1, V_FET};
`endif
    Op = 2'b11; Funct = 6'b111111;
    for (int i = 0; i < N; i++) begin
      MemReady = tv[i][13];
      @(negedge clk);
      nvec++;
      if (obs !== tv[i][12:0]) begin
        nerr++;
        $display("FAIL undef cycle %0d: got %b want %b", i, obs, tv[i][12:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_dp_reg();
    test_ldr_stall();
    test_str_stall();
    test_branch();
    test_back_to_back();
    test_reset_mid_memwr();
    test_undef();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
